// File: rtl/cpu_run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_pkg
// Shared types and constants for the CPU run/step/scan controller.
//   run_state_e : controller FSM states (HALT, RUN, STEP, SCAN)
//   IO_*        : CPU I/O bus address map decoded by the controller
// ---------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        SCAN = 2'd3
    } run_state_e;

    localparam logic [7:0] IO_LED  = 8'h00;
    localparam logic [7:0] IO_SEG  = 8'h08;
    localparam logic [7:0] IO_STAT = 8'h0C;
    localparam logic [7:0] IO_IN   = 8'h10;

    // True when the I/O bus address selects the given register
    function automatic logic io_sel(input logic [7:0] addr, input logic [7:0] target);
        return addr == target;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
// Bundle of every signal running between the run controller and the CPU.
//   cpu_en     : controller -> CPU, clock enable for PC/RF/MEM
//   io_addr    : CPU -> controller, I/O bus address
//   io_dout    : CPU -> controller, I/O write data
//   io_we      : CPU -> controller, I/O write strobe
//   io_din     : controller -> CPU, I/O read data (combinational)
//   m_rf_addr  : controller -> CPU, debug read address
//   rf_data    : CPU -> controller, register file debug word
//   m_data     : CPU -> controller, memory debug word
//   pc         : CPU -> controller, current program counter
// Modports: master = controller side, slave = CPU side.
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int SCAN_W = 8
);
    logic              cpu_en;
    logic [7:0]        io_addr;
    logic [31:0]       io_dout;
    logic              io_we;
    logic [31:0]       io_din;
    logic [SCAN_W-1:0] m_rf_addr;
    logic [31:0]       rf_data;
    logic [31:0]       m_data;
    logic [31:0]       pc;

    modport master (
        output cpu_en,
        output io_din,
        output m_rf_addr,
        input  io_addr,
        input  io_dout,
        input  io_we,
        input  rf_data,
        input  m_data,
        input  pc
    );

    modport slave (
        input  cpu_en,
        input  io_din,
        input  m_rf_addr,
        output io_addr,
        output io_dout,
        output io_we,
        output rf_data,
        output m_data,
        output pc
    );
endinterface

// File: rtl/cpu_run_ctrl_io_mbox.sv
// ---------------------------------------------------------------------------
// cpu_io_mbox
// Switch-input mailbox plus the controller's I/O read mux.
//   clk, rst  : system clock, synchronous active-high reset
//   in_vld    : pulse, latch sw_data and mark the mailbox full
//   sw_data   : board switch data (IN_W bits, zero-extended on read)
//   io_addr   : CPU I/O bus address
//   rd_en     : a CPU read is really executing this cycle (cpu_en && !io_we)
//   rd_data   : combinational read data for io_din
// ---------------------------------------------------------------------------
module cpu_io_mbox
    import cpu_run_ctrl_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [IN_W-1:0] sw_data,
    input  logic [7:0]      io_addr,
    input  logic            rd_en,
    output logic [31:0]     rd_data
);

    logic            mbox_full_q, mbox_full_d;
    logic [IN_W-1:0] mbox_data_q, mbox_data_d;
    logic            rd_clr;

    assign rd_clr = rd_en && io_sel(io_addr, IO_IN);

    // Mailbox update: a consuming read empties it, but a fresh in_vld in the
    // same cycle is applied last so the new value survives and stays full.
    always_comb begin
        mbox_full_d = mbox_full_q;
        mbox_data_d = mbox_data_q;
        if (rd_clr) begin
            mbox_full_d = 1'b0;
        end
        if (in_vld) begin
            mbox_full_d = 1'b1;
            mbox_data_d = sw_data;
        end
    end

    // Read mux; reads while the CPU is frozen are side-effect free.
    always_comb begin
        rd_data = 32'h0;
        if (io_sel(io_addr, IO_STAT)) begin
            rd_data = {31'b0, mbox_full_q};
        end else if (io_sel(io_addr, IO_IN)) begin
            rd_data = 32'(mbox_data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mbox_full_q <= 1'b0;
            mbox_data_q <= '0;
        end else begin
            mbox_full_q <= mbox_full_d;
            mbox_data_q <= mbox_data_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run/step/scan controller for the single-cycle CPU. Gates execution with
// cpu_en, decodes the CPU I/O bus into LED/SEG registers and the switch
// mailbox, and while halted scans RF or MEM words to the debug display path.
// Optional feature macro: BREAKPOINT_EN (adds bp_addr, bp_en, bp_hit).
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   run                  : level, 1 = free-run, 0 = halt
//   step                 : pulse, execute one instruction from HALT
//   in_vld, sw_data      : switch mailbox write
//   scan_req, scan_mem   : start a debug scan (MEM when scan_mem=1, else RF)
//   scan_base, scan_len  : first scan address, word count (0 = 2^SCAN_W)
//   bp_addr, bp_en       : breakpoint PC and enable (BREAKPOINT_EN only)
//   bp_hit               : halted on breakpoint (BREAKPOINT_EN only)
//   cpu                  : CPU-side bus (cpu_run_ctrl_if master modport)
//   led, seg             : board output registers
//   dbg_data, dbg_vld    : registered scan word and its strobe
//   busy                 : 1 while in STEP or SCAN
// ---------------------------------------------------------------------------
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int SCAN_W = 8,
    parameter int LED_W  = 8,
    parameter int IN_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              in_vld,
    input  logic [IN_W-1:0]   sw_data,
    input  logic              scan_req,
    input  logic              scan_mem,
    input  logic [SCAN_W-1:0] scan_base,
    input  logic [SCAN_W-1:0] scan_len,
`ifdef BREAKPOINT_EN
    input  logic [31:0]       bp_addr,
    input  logic              bp_en,
    output logic              bp_hit,
`endif
    cpu_run_ctrl_if.master    cpu,
    output logic [LED_W-1:0]  led,
    output logic [31:0]       seg,
    output logic [31:0]       dbg_data,
    output logic              dbg_vld,
    output logic              busy
);

    run_state_e        state_q, state_d;
    logic [SCAN_W-1:0] addr_q, addr_d;
    logic [SCAN_W-1:0] rem_q, rem_d;
    logic              sel_q, sel_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       seg_q, seg_d;
    logic [31:0]       dbg_data_q, dbg_data_d;
    logic              dbg_vld_q, dbg_vld_d;
    logic              cpu_en;
    logic              bp_match;
    logic              wr_en;
    logic [31:0]       io_din;

`ifdef BREAKPOINT_EN
    logic bp_hit_q, bp_hit_d;

    assign bp_match = bp_en && (cpu.pc == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    // Next-state logic. From HALT the priority is run > step > scan_req;
    // every request is ignored outside HALT, so a step during RUN or a
    // scan_req during SCAN never disturbs the current activity.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: begin
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end else if (scan_req) begin
                    state_d = SCAN;
                end
            end
            RUN: begin
                if (!run || bp_match) begin
                    state_d = HALT;
                end
            end
            STEP: begin
                state_d = HALT;
            end
            SCAN: begin
                if (rem_q == '0) begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // State-decoded outputs. A breakpoint match suppresses the enable in the
    // very cycle it is detected so the instruction at bp_addr is not run;
    // STEP ignores the comparator, which lets a step leave a breakpoint.
    always_comb begin
        cpu_en = 1'b0;
        busy   = 1'b0;
        case (state_q)
            RUN:     cpu_en = !bp_match;
            STEP: begin
                cpu_en = 1'b1;
                busy   = 1'b1;
            end
            SCAN:    busy   = 1'b1;
            default: cpu_en = 1'b0;
        endcase
    end

    // Scan datapath. rem holds the words still to go after the current one,
    // so loading len-1 makes len=0 naturally scan all 2^SCAN_W words. The
    // address stops on the last word so m_rf_addr holds it after the scan.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        sel_d      = sel_q;
        dbg_data_d = dbg_data_q;
        dbg_vld_d  = 1'b0;
        if (state_q == HALT && state_d == SCAN) begin
            addr_d = scan_base;
            rem_d  = scan_len - SCAN_W'(1);
            sel_d  = scan_mem;
        end
        if (state_q == SCAN) begin
            dbg_data_d = sel_q ? cpu.m_data : cpu.rf_data;
            dbg_vld_d  = 1'b1;
            if (rem_q != '0) begin
                addr_d = addr_q + SCAN_W'(1);
                rem_d  = rem_q - SCAN_W'(1);
            end
        end
    end

    // LED/SEG output registers; a write only counts when the CPU is enabled.
    assign wr_en = cpu.io_we && cpu_en;

    always_comb begin
        led_d = led_q;
        seg_d = seg_q;
        if (wr_en && io_sel(cpu.io_addr, IO_LED)) begin
            led_d = cpu.io_dout[LED_W-1:0];
        end
        if (wr_en && io_sel(cpu.io_addr, IO_SEG)) begin
            seg_d = cpu.io_dout;
        end
    end

`ifdef BREAKPOINT_EN
    // bp_hit is set on the halting match and cleared as soon as a run or step
    // leaves HALT again.
    always_comb begin
        bp_hit_d = bp_hit_q;
        if (state_q == HALT && (state_d == RUN || state_d == STEP)) begin
            bp_hit_d = 1'b0;
        end
        if (state_q == RUN && bp_match) begin
            bp_hit_d = 1'b1;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HALT;
            addr_q     <= '0;
            rem_q      <= '0;
            sel_q      <= 1'b0;
            led_q      <= '0;
            seg_q      <= '0;
            dbg_data_q <= '0;
            dbg_vld_q  <= 1'b0;
`ifdef BREAKPOINT_EN
            bp_hit_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            dbg_data_q <= dbg_data_d;
            dbg_vld_q  <= dbg_vld_d;
`ifdef BREAKPOINT_EN
            bp_hit_q   <= bp_hit_d;
`endif
        end
    end

    cpu_io_mbox #(
        .IN_W (IN_W)
    ) u_mbox (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .sw_data (sw_data),
        .io_addr (cpu.io_addr),
        .rd_en   (cpu_en && !cpu.io_we),
        .rd_data (io_din)
    );

    assign cpu.cpu_en    = cpu_en;
    assign cpu.io_din    = io_din;
    assign cpu.m_rf_addr = addr_q;
    assign led           = led_q;
    assign seg           = seg_q;
    assign dbg_data      = dbg_data_q;
    assign dbg_vld       = dbg_vld_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl. A tiny CPU stand-in advances pc by 4
// on every enabled cycle and exposes fixed RF/MEM word patterns; expected
// results come from the controller's documented rules applied per scenario.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int SCAN_W = 8;
    localparam int LED_W  = 8;
    localparam int IN_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              run, step, in_vld, scan_req, scan_mem;
    logic [IN_W-1:0]   sw_data;
    logic [SCAN_W-1:0] scan_base, scan_len;
    logic [LED_W-1:0]  led;
    logic [31:0]       seg, dbg_data;
    logic              dbg_vld, busy;
`ifdef BREAKPOINT_EN
    logic [31:0]       bp_addr;
    logic              bp_en, bp_hit;
`endif

    cpu_run_ctrl_if #(.SCAN_W(SCAN_W)) cpu ();

    cpu_run_ctrl #(
        .SCAN_W (SCAN_W),
        .LED_W  (LED_W),
        .IN_W   (IN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .in_vld    (in_vld),
        .sw_data   (sw_data),
        .scan_req  (scan_req),
        .scan_mem  (scan_mem),
        .scan_base (scan_base),
        .scan_len  (scan_len),
`ifdef BREAKPOINT_EN
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .bp_hit    (bp_hit),
`endif
        .cpu       (cpu),
        .led       (led),
        .seg       (seg),
        .dbg_data  (dbg_data),
        .dbg_vld   (dbg_vld),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // CPU stand-in: one instruction per enabled cycle, fixed debug patterns
    function automatic logic [31:0] rf_word(input logic [7:0] a);
        return 32'hA500_0000 | {24'h0, a};
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return 32'h5A00_0000 | {22'h0, a, 2'b00};
    endfunction

    logic [31:0] pc_q = 32'h0;

    always @(posedge clk) begin
        if (cpu.cpu_en === 1'b1) pc_q <= pc_q + 32'd4;
    end

    assign cpu.pc      = pc_q;
    assign cpu.rf_data = rf_word(cpu.m_rf_addr);
    assign cpu.m_data  = mem_word(cpu.m_rf_addr);

    int          vec_count  = 0;
    int          miss_count = 0;
    int          en_count   = 0;
    logic [7:0]  addr_log[$];
    logic [31:0] data_log[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge and record what the DUT shows
    task automatic tick();
        @(negedge clk);
        if (cpu.cpu_en === 1'b1) en_count++;
        if (busy === 1'b1) addr_log.push_back(cpu.m_rf_addr);
        if (dbg_vld === 1'b1) data_log.push_back(dbg_data);
    endtask

    // Drive run (level) and step/scan_req (one-cycle pulses), then idle
    task automatic applyStimulus(input logic run_v, input logic step_v, input logic scan_v, input int hold);
        run      = run_v;
        step     = step_v;
        scan_req = scan_v;
        tick();
        step     = 1'b0;
        scan_req = 1'b0;
        repeat (hold) tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] pc0, val, v1, v2;
        logic [7:0]  exp_led;
        logic [31:0] exp_seg;
        logic [7:0]  base_c[6];
        int          len_c[6];
        int          n, waited, lim, run_len;

        rst = 1'b1; run = 1'b0; step = 1'b0; in_vld = 1'b0; scan_req = 1'b0;
        scan_mem = 1'b0; sw_data = '0; scan_base = '0; scan_len = '0;
        cpu.io_addr = IO_STAT; cpu.io_dout = '0; cpu.io_we = 1'b0;
`ifdef BREAKPOINT_EN
        bp_addr = '0; bp_en = 1'b0;
`endif
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("rst_cpu_en", cpu.cpu_en, 0);
        checkOutput("rst_led", led, 0);
        checkOutput("rst_seg", seg, 0);
        checkOutput("rst_dbg_data", dbg_data, 0);
        checkOutput("rst_dbg_vld", dbg_vld, 0);
        checkOutput("rst_m_rf_addr", cpu.m_rf_addr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mbox_stat", cpu.io_din, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single steps");
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? 3 : $urandom_range(1, 5);
            en_count = 0;
            pc0 = pc_q;
            repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, $urandom_range(1, 3));
            checkOutput("step_en_count", en_count, n);
            checkOutput("step_pc", pc_q, pc0 + 32'(4 * n));
        end

        $display("[TB] LED/SEG writes");
        exp_led = '0;
        exp_seg = '0;
        for (int k = 0; k < 6; k++) begin
            val = $urandom;
            cpu.io_addr = (k % 3 == 0) ? IO_LED : (k % 3 == 1) ? IO_SEG : 8'h04;
            cpu.io_dout = val;
            cpu.io_we   = 1'b1;
            repeat (3) tick();
            checkOutput("io_halted_led", led, exp_led);
            checkOutput("io_halted_seg", seg, exp_seg);
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            cpu.io_we = 1'b0;
            if (k % 3 == 0) exp_led = val[7:0];
            if (k % 3 == 1) exp_seg = val;
            checkOutput("io_led", led, exp_led);
            checkOutput("io_seg", seg, exp_seg);
        end
        cpu.io_addr = IO_STAT;

        $display("[TB] free run");
        for (int r = 0; r < 3; r++) begin
            run_len = (r == 0) ? 10 : $urandom_range(6, 20);
            en_count = 0;
            addr_log.delete();
            pc0 = pc_q;
            applyStimulus(1'b1, r == 1, r == 2, 2);
            step = 1'b1; scan_req = 1'b1;
            tick();
            step = 1'b0; scan_req = 1'b0;
            repeat (run_len - 4) tick();
            run = 1'b0;
            repeat (4) tick();
            checkOutput("run_en_count", en_count, run_len);
            checkOutput("run_pc", pc_q, pc0 + 32'(4 * run_len));
            checkOutput("run_never_busy", addr_log.size(), 0);
            checkOutput("run_led_hold", led, exp_led);
            checkOutput("run_seg_hold", seg, exp_seg);
        end

        $display("[TB] debug scans");
        base_c = '{8'h00, 8'hFE, 8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom))};
        len_c  = '{4, 3, $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8), 256};
        for (int c = 0; c < 6; c++) begin
            n = len_c[c];
            addr_log.delete();
            data_log.delete();
            en_count  = 0;
            scan_base = base_c[c];
            scan_len  = 8'(n);
            scan_mem  = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b0, 1'b1, 0);
            waited = 0;
            while (data_log.size() < n && waited < n + 4) begin
                if (n == 256 && waited == 5) begin
                    run = 1'b1; step = 1'b1; scan_req = 1'b1;
                end else begin
                    run = 1'b0; step = 1'b0; scan_req = 1'b0;
                end
                tick();
                waited++;
            end
            run = 1'b0; step = 1'b0; scan_req = 1'b0;
            checkOutput("scan_busy_done", busy, 0);
            checkOutput("scan_word_count", data_log.size(), n);
            checkOutput("scan_addr_count", addr_log.size(), n);
            checkOutput("scan_no_cpu_en", en_count, 0);
            lim = (data_log.size() < addr_log.size()) ? data_log.size() : addr_log.size();
            if (lim > n) lim = n;
            for (int i = 0; i < lim; i++) begin
                checkOutput("scan_addr", addr_log[i], 8'(base_c[c] + 8'(i)));
                checkOutput("scan_data", data_log[i],
                            scan_mem ? mem_word(8'(base_c[c] + 8'(i))) : rf_word(8'(base_c[c] + 8'(i))));
            end
            repeat (2) tick();
            checkOutput("scan_addr_hold", cpu.m_rf_addr, 8'(base_c[c] + 8'(n - 1)));
            checkOutput("scan_vld_idle", dbg_vld, 0);
        end

        $display("[TB] switch mailbox");
        cpu.io_we = 1'b0;
        cpu.io_addr = IO_STAT;
        tick();
        checkOutput("mbox_empty", cpu.io_din, 0);
        v1 = (($urandom % 2) == 0) ? 32'h1234 : $urandom;
        n = $urandom_range(1, 4);
        for (int w = 0; w < 10; w++) begin
            in_vld  = (w == n);
            sw_data = v1;
            tick();
            if (cpu.io_din[0] === 1'b1) break;
        end
        in_vld = 1'b0;
        checkOutput("mbox_poll_full", cpu.io_din, 1);
        cpu.io_addr = IO_IN;
        tick();
        checkOutput("mbox_data", cpu.io_din, v1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        cpu.io_addr = IO_STAT;
        tick();
        checkOutput("mbox_read_clears", cpu.io_din, 0);

        v1 = $urandom; v2 = $urandom;
        in_vld = 1'b1; sw_data = v1; tick();
        sw_data = v2; tick();
        in_vld = 1'b0;
        cpu.io_addr = IO_IN;
        tick();
        checkOutput("mbox_overwrite", cpu.io_din, v2);

        v1 = $urandom;
        step = 1'b1;
        tick();
        step = 1'b0; in_vld = 1'b1; sw_data = v1;
        tick();
        in_vld = 1'b0;
        cpu.io_addr = IO_STAT;
        tick();
        checkOutput("mbox_race_full", cpu.io_din, 1);
        cpu.io_addr = IO_IN;
        tick();
        checkOutput("mbox_race_data", cpu.io_din, v1);
        cpu.io_addr = 8'h04;
        tick();
        checkOutput("io_unmapped_read", cpu.io_din, 0);

        $display("[TB] reset aborts");
        scan_base = 8'h10; scan_len = 8'h00; scan_mem = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        rst = 1'b1;
        tick();
        cpu.io_addr = IO_STAT;
        checkOutput("abort_scan_busy", busy, 0);
        checkOutput("abort_scan_m_rf_addr", cpu.m_rf_addr, 0);
        checkOutput("abort_led", led, 0);
        tick();
        checkOutput("abort_scan_vld", dbg_vld, 0);
        checkOutput("abort_dbg_data", dbg_data, 0);
        checkOutput("abort_mbox_empty", cpu.io_din, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("abort_run_active", cpu.cpu_en, 1);
        rst = 1'b1;
        tick();
        checkOutput("abort_run_cpu_en", cpu.cpu_en, 0);
        run = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checkOutput("abort_run_stays_halted", cpu.cpu_en, 0);

`ifdef BREAKPOINT_EN
        $display("[TB] breakpoint");
        bp_addr = pc_q + 32'd8;
        bp_en   = 1'b1;
        run     = 1'b1;
        repeat (12) tick();
        run = 1'b0;
        repeat (3) tick();
        checkOutput("bp_pc", pc_q, bp_addr);
        checkOutput("bp_hit_set", bp_hit, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        checkOutput("bp_step_pc", pc_q, bp_addr + 32'd4);
        checkOutput("bp_hit_clear", bp_hit, 0);
        bp_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
